// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM state encoding
// and the width of one adder slice.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca.sv
// 4-bit ripple carry adder: s = a + b + ci, co = carry out of bit 3.
module _4RCA
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic                co,
  output logic [NIBBLE_W-1:0] s
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit add/subtract sequenced over a single 4-bit ripple adder, one nibble
// per clock, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sub,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          ci,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   s,
  output logic                          co,
  output logic                          ovf
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        s_r;
  logic [W-1:0]        s_next;
  logic                co_r;
  logic                ovf_r;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                rca_co;
  logic                last;

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_r[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  _4RCA u_rca (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .co (rca_co),
    .s  (sum_nib)
  );

  // Only the active nibble is overwritten; upper nibbles keep the old result.
  always_comb begin
    s_next = s_r;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) s_next[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          s_r   <= s_next;
          carry <= rca_co;
          if (last) begin
            idx   <= '0;
            co_r  <= rca_co;
            ovf_r <= a_r[W-1] ^ b_r[W-1] ^ sum_nib[NIBBLE_W-1] ^ rca_co;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign s    = s_r;
  assign co   = co_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES = 4, W = 16).
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  int   last_done_cyc = -1;
  bit   hold_mode = 1'b0;
  logic prev_done = 1'b0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tci, input logic tsub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb    = tsub ? ~tb : tb;
    r     = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, (tsub ? 1'b1 : tci)};
    e.s   = r[W-1:0];
    e.co  = r[W];
    e.ovf = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: one expected entry per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      check("done_single", prev_done, 1'b0);
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("s", s, e.s);
        check("co", co, e.co);
        check("ovf", ovf, e.ovf);
      end
      if (hold_mode && last_done_cyc >= 0) check("hold_period", cyc - last_done_cyc, NIB + 2);
      last_done_cyc = cyc;
      done_cnt++;
    end
    prev_done = done;
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub, input bit disturb);
    @(negedge clk);
    a = ta; b = tb; ci = tci; sub = tsub; start = 1'b1;
    sb.push_back(model(ta, tb, tci, tsub));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      check("busy_run", busy, 1'b1);
      if (disturb && k == 1) begin
        start = 1'b1; a = ~ta; b = 16'h0F0F; sub = ~tsub; ci = ~tci;
      end
      if (disturb && k == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    check("busy_end", busy, 1'b0);
    check("done_latency", done, 1'b1);
    @(posedge clk); #1;
    check("done_clear", done, 1'b0);
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
    @(negedge clk);
    check("rst_s", s, 16'h0);
    check("rst_co", co, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset two RUN edges into an operation.
    @(negedge clk);
    a = 16'hA55A; b = 16'h0F0F; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_s", s, 16'h0);
    check("midrst_co", co, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_op(16'hA55A, 16'h0F0F, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 4; n++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    // start held high: one operation per NIB+2 cycles.
    @(negedge clk);
    a = 16'h89AB; b = 16'h7654; ci = 1'b1; sub = 1'b0; start = 1'b1;
    base = done_cnt;
    last_done_cyc = -1;
    hold_mode = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(16'h89AB, 16'h7654, 1'b1, 1'b0));
    for (int t = 0; t < 40 && done_cnt < base + 3; t++) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    hold_mode = 1'b0;
    check("hold_count", done_cnt - base, 3);
    repeat (10) @(posedge clk);
    #2;
    check("hold_no_extra", done_cnt - base, 3);
    check("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
